// File: rtl/icp_mem.sv
// rtl/icp_mem.sv - four-port read-first data memory with zero-fill clear and host load
module icp_mem #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 13,
  parameter int DEPTH     = 8192
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [NUM_PORTS-1:0][1:0]          i_op,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]   i_addr,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]   i_data,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]   o_data,
  input  logic                               i_load_en,
  input  logic [ADDR_W-1:0]                  i_load_addr,
  input  logic [DATA_W-1:0]                  i_load_data,
  output logic                               o_ready,
  output logic                               o_conflict,
  output logic                               o_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t                             state_q, state_d;
  logic [IDX_W-1:0]                   clr_q, clr_d;
  logic                               clr_we;
  logic [DATA_W-1:0]                  mem_q [DEPTH];
  logic [NUM_PORTS-1:0][DATA_W-1:0]   data_q;
  logic                               conflict_q, conflict_d;
  logic                               err_q, err_d;
  logic [NUM_PORTS-1:0]               rd_en, wr_ok;
  logic                               ld_ok, conflict_hit, err_hit;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return int'({1'b0, a}) < DEPTH;
  endfunction

  function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    if (state_q == S_CLEAR) begin
      clr_d = clr_q + 1'b1;
      if (clr_q == IDX_W'(DEPTH - 1)) state_d = S_READY;
    end
  end

  always_comb begin
    o_ready = (state_q == S_READY);
    clr_we  = (state_q == S_CLEAR);
  end

  always_comb begin
    rd_en        = '0;
    wr_ok        = '0;
    err_hit      = 1'b0;
    conflict_hit = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_en[p] = (i_op[p] == OP_READ);
      wr_ok[p] = (i_op[p] == OP_WRITE) && in_range(i_addr[p]);
      if ((i_op[p] == OP_READ || i_op[p] == OP_WRITE) && !in_range(i_addr[p])) err_hit = 1'b1;
    end
    ld_ok = i_load_en && in_range(i_load_addr);
    if (i_load_en && !in_range(i_load_addr)) err_hit = 1'b1;
    // Only writes that would actually commit can collide.
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (wr_ok[i] && ld_ok && i_addr[i] == i_load_addr) conflict_hit = 1'b1;
      for (int j = i + 1; j < NUM_PORTS; j++)
        if (wr_ok[i] && wr_ok[j] && i_addr[i] == i_addr[j]) conflict_hit = 1'b1;
    end
    conflict_d = conflict_q | conflict_hit;
    err_d      = err_q | err_hit;
  end

  // Later assignments win, so the load goes first and port 0 last.
  always_ff @(posedge i_clk) begin
    if (clr_we) begin
      mem_q[clr_q] <= '0;
    end else begin
      if (ld_ok) mem_q[idx(i_load_addr)] <= i_load_data;
      for (int p = NUM_PORTS - 1; p >= 0; p--)
        if (wr_ok[p]) mem_q[idx(i_addr[p])] <= i_data[p];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q <= '0;
    end else if (o_ready) begin
      for (int p = 0; p < NUM_PORTS; p++)
        if (rd_en[p]) data_q[p] <= in_range(i_addr[p]) ? mem_q[idx(i_addr[p])] : '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      conflict_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (o_ready) begin
      conflict_q <= conflict_d;
      err_q      <= err_d;
    end
  end

  assign o_data     = data_q;
  assign o_conflict = conflict_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_icp_mem.sv
// tb/tb_icp_mem.sv - directed scoreboard bench for icp_mem at DEPTH=64
module tb_icp_mem;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int AW = 13;
  localparam int DEPTH = 64;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NP-1:0][1:0]      op;
  logic [NP-1:0][AW-1:0]   addr;
  logic [NP-1:0][DW-1:0]   wdata;
  logic [NP-1:0][DW-1:0]   rdata;
  logic                    load_en;
  logic [AW-1:0]           load_addr;
  logic [DW-1:0]           load_data;
  logic                    ready, conflict, err;

  typedef struct {
    int          port;
    logic [DW-1:0] val;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [DEPTH];
  int            n_assert = 0;
  int            n_fail   = 0;

  icp_mem #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_op(op), .i_addr(addr), .i_data(wdata), .o_data(rdata),
    .i_load_en(load_en), .i_load_addr(load_addr), .i_load_data(load_data),
    .o_ready(ready), .o_conflict(conflict), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle;
    op      = '0;
    load_en = 1'b0;
  endtask

  task automatic rd(input int p, input int a);
    op[p]   = 2'd1;
    addr[p] = AW'(a);
    sb.push_back('{p, (a < DEPTH) ? model[a] : '0});
  endtask

  task automatic wr(input int p, input int a, input logic [DW-1:0] d);
    op[p]    = 2'd2;
    addr[p]  = AW'(a);
    wdata[p] = d;
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(tag, rdata[e.port], e.val);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    addr = '0;
    wdata = '0;
    load_addr = '0;
    load_data = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    repeat (2) tick();
    chk("rst_ready", ready, 0);
    chk("rst_conflict", conflict, 0);
    chk("rst_err", err, 0);
    chk("rst_data", rdata, '0);

    rst = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      chk("clear_ready", ready, (k == DEPTH) ? 1 : 0);
    end

    for (int s = 0; s < DEPTH / NP; s++) begin
      for (int p = 0; p < NP; p++) rd(p, s * NP + p);
      tick();
      drain("read_zero");
    end
    idle();

    for (int a = 0; a < 4; a++) begin
      load_en   = 1'b1;
      load_addr = AW'(a);
      load_data = (a == 0) ? 64'd1 : (a == 3) ? 64'd99 : 64'd0;
      model[a]  = load_data;
      tick();
    end
    idle();
    for (int h = 0; h < 2; h++) begin
      for (int p = 0; p < NP; p++) rd(p, p);
      tick();
      drain("load_read");
    end
    idle();

    wr(0, 5, 64'h1234);
    rd(1, 5);
    tick();
    drain("rd_first_old");
    model[5] = 64'h1234;
    op[0] = 2'd0;
    rd(1, 5);
    tick();
    drain("rd_first_new");
    idle();
    chk("no_conflict_yet", conflict, 0);
    chk("no_err_yet", err, 0);

    wr(0, 7, 64'hA);
    wr(2, 7, 64'hB);
    wr(3, 8, 64'hC);
    tick();
    idle();
    model[7] = 64'hA;
    model[8] = 64'hC;
    chk("conflict_set", conflict, 1);
    rd(0, 7);
    rd(3, 8);
    tick();
    drain("write_priority");
    idle();

    rd(1, 100);
    tick();
    drain("oor_read");
    idle();
    chk("err_set", err, 1);
    wr(1, 100, 64'hDEAD);
    tick();
    idle();
    rd(2, 36);
    rd(3, 100 - DEPTH);
    tick();
    drain("oor_write_dropped");
    idle();
    chk("err_sticky", err, 1);
    chk("conflict_sticky", conflict, 1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (30) tick();
    chk("midclear_ready", ready, 0);
    rst = 1'b1;
    #1;
    chk("rerst_conflict", conflict, 0);
    chk("rerst_err", err, 0);
    chk("rerst_data", rdata, '0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      chk("reclear_ready", ready, (k == DEPTH) ? 1 : 0);
    end
    rd(0, 3);
    rd(1, 0);
    rd(2, 7);
    tick();
    drain("reclear_zero");
    idle();
    chk("reclear_conflict", conflict, 0);
    chk("reclear_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
